// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI burst/size types shared by the downsizer paths
package axi_pkg;

  typedef logic [1:0] burst_t;
  typedef logic [2:0] size_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;

endpackage

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - Non-fall-through synchronous FIFO with typed payload
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned AddrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);

  dtype             mem_q [DEPTH];
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_dw_downsizer_w.sv
// rtl/axi_dw_downsizer_w.sv - W-channel engine splitting wide beats into narrow beats
module axi_dw_downsizer_w
  import axi_pkg::*;
#(
  parameter int unsigned SlvDataWidth = 256,
  parameter int unsigned MstDataWidth = 32,
  parameter int unsigned UserWidth    = 8,
  parameter int unsigned CmdDepth     = 4,
  localparam int unsigned SlvOffW     = $clog2(SlvDataWidth/8),
  localparam int unsigned MstSizeMax  = $clog2(MstDataWidth/8)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [SlvOffW-1:0]        cmd_offset_i,
  input  logic [2:0]                cmd_size_i,
  input  logic [7:0]                cmd_len_i,
  input  logic [1:0]                cmd_burst_i,
  input  logic [SlvDataWidth-1:0]   slv_w_data_i,
  input  logic [SlvDataWidth/8-1:0] slv_w_strb_i,
  input  logic [UserWidth-1:0]      slv_w_user_i,
  input  logic                      slv_w_last_i,
  input  logic                      slv_w_valid_i,
  output logic                      slv_w_ready_o,
  output logic [MstDataWidth-1:0]   mst_w_data_o,
  output logic [MstDataWidth/8-1:0] mst_w_strb_o,
  output logic [UserWidth-1:0]      mst_w_user_o,
  output logic                      mst_w_last_o,
  output logic                      mst_w_valid_o,
  input  logic                      mst_w_ready_i,
  output logic                      len_err_o
);

  localparam int unsigned NumLanes = SlvDataWidth / MstDataWidth;
  localparam int unsigned LaneW    = SlvOffW - MstSizeMax;

  typedef struct packed {
    logic [SlvOffW-1:0] offset;
    size_t              size;
    logic [7:0]         len;
    burst_t             burst;
  } cmd_t;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e             state_q, state_d;
  logic [SlvOffW-1:0] offset_q, offset_d;
  size_t              size_q, size_d;
  logic [7:0]         len_q, len_d;
  burst_t             burst_q, burst_d;
  logic [7:0]         beat_cnt_q, beat_cnt_d;
  logic               len_err_q, len_err_d;

  cmd_t cmd_in, cmd_head;
  logic cmd_full, cmd_empty, cmd_pop;

  assign cmd_in = '{offset: cmd_offset_i, size: cmd_size_i, len: cmd_len_i, burst: cmd_burst_i};
  assign cmd_ready_o = ~cmd_full;

  fifo_v3 #(
    .DEPTH (CmdDepth),
    .dtype (cmd_t)
  ) i_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (cmd_full),
    .empty_o (cmd_empty),
    .data_i  (cmd_in),
    .push_i  (cmd_valid_i),
    .data_o  (cmd_head),
    .pop_i   (cmd_pop)
  );

  logic [NumLanes-1:0][MstDataWidth-1:0]   data_lanes;
  logic [NumLanes-1:0][MstDataWidth/8-1:0] strb_lanes;
  logic [LaneW-1:0]   lane;
  logic [SlvOffW-1:0] size_mask, aligned;
  logic [SlvOffW:0]   next_sum;
  logic               carry, narrow_last, pop_cond;
  size_t              size_clamped;

  assign data_lanes = slv_w_data_i;
  assign strb_lanes = slv_w_strb_i;
  assign lane       = offset_q[SlvOffW-1:MstSizeMax];
  assign size_mask  = (SlvOffW'(1) << size_q) - SlvOffW'(1);
  assign aligned    = offset_q & ~size_mask;
  // The extra top bit flags that the next narrow address leaves this wide beat.
  assign next_sum   = {1'b0, aligned} + ((SlvOffW+1)'(1) << size_q);
  assign carry      = next_sum[SlvOffW];
  assign size_clamped = (cmd_head.size > size_t'(MstSizeMax)) ? size_t'(MstSizeMax)
                                                              : cmd_head.size;

  assign mst_w_data_o = data_lanes[lane];
  assign mst_w_strb_o = strb_lanes[lane];
  assign mst_w_user_o = slv_w_user_i;
  assign len_err_o    = len_err_q;

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    size_d        = size_q;
    len_d         = len_q;
    burst_d       = burst_q;
    beat_cnt_d    = beat_cnt_q;
    len_err_d     = 1'b0;
    cmd_pop       = 1'b0;
    narrow_last   = 1'b0;
    pop_cond      = 1'b0;
    mst_w_valid_o = 1'b0;
    mst_w_last_o  = 1'b0;
    slv_w_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop    = 1'b1;
          offset_d   = cmd_head.offset;
          size_d     = size_clamped;
          len_d      = cmd_head.len;
          burst_d    = cmd_head.burst;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        narrow_last   = (beat_cnt_q == len_q);
        pop_cond      = narrow_last | (burst_q == BURST_FIXED) | carry;
        mst_w_valid_o = slv_w_valid_i;
        mst_w_last_o  = narrow_last;
        slv_w_ready_o = mst_w_ready_i & pop_cond;
        if (slv_w_valid_i && mst_w_ready_i) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (burst_q != BURST_FIXED) offset_d = next_sum[SlvOffW-1:0];
          if (narrow_last) state_d = IDLE;
        end
        if (slv_w_valid_i && slv_w_ready_o && (slv_w_last_i != narrow_last)) len_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      offset_q   <= '0;
      size_q     <= '0;
      len_q      <= '0;
      burst_q    <= BURST_INCR;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      size_q     <= size_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule
